// File: rtl/fmt_field_sched.sv
// fmt_field_sched: one integer-to-ASCII field formatter shared by N_REQ requesters.
// A round-robin arbiter grants one request and the digits are generated into a stack
// (LSD first). The field is then streamed MSD first, one char per beat, padded with
// spaces to the requested width.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req_valid / req_ready    per-requester request handshake (ready is a one-cycle one-hot pulse)
//   req_conv/value/width     per-requester radix (b/o/d/h), unsigned value, min field width
//   req_left / req_min       per-requester left-justify flag, minimal-digit flag
//   out_valid/ready/char     character stream to the sink
//   out_last / out_src       last char of the field, owning requester index
//   busy                     high whenever the block is not idle
module fmt_field_sched #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [2*N_REQ-1:0]      req_conv,
    input  logic [DATA_W*N_REQ-1:0] req_value,
    input  logic [5*N_REQ-1:0]      req_width,
    input  logic [N_REQ-1:0]        req_left,
    input  logic [N_REQ-1:0]        req_min,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_char,
    output logic                    out_last,
    output logic [IDX_W-1:0]        out_src,
    output logic                    busy
);
    localparam int unsigned MAXL = (DATA_W > 31) ? DATA_W : 31;
    localparam int unsigned PW   = $clog2(MAXL + 1) + 1;
    localparam int unsigned SW   = $clog2(DATA_W);
    localparam int unsigned ND_O = (DATA_W + 2) / 3;
    localparam int unsigned ND_H = (DATA_W + 3) / 4;
    // ceil(DATA_W * log10(2))
    localparam int unsigned ND_D = (DATA_W * 30103 + 99999) / 100000;

    typedef enum logic [2:0] {StIdle, StLoad, StGen, StLpad, StDig, StRpad} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_q, grant_q;
    logic [1:0]         conv_q;
    logic [DATA_W-1:0]  val_q;
    logic [4:0]         width_q;
    logic               left_q, min_q;
    logic [3:0]         rem_q;
    logic [SW-1:0]      bitcnt_q;
    logic [3:0]         stack_q [DATA_W];
    logic [PW-1:0]      ndig_q, pos_q;
    logic               seen_q;

    // Unpack the per-requester buses.
    logic [1:0]        conv_arr  [N_REQ];
    logic [DATA_W-1:0] value_arr [N_REQ];
    logic [4:0]        width_arr [N_REQ];
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            conv_arr[k]  = req_conv[2*k +: 2];
            value_arr[k] = req_value[DATA_W*k +: DATA_W];
            width_arr[k] = req_width[5*k +: 5];
        end
    end

    // Round-robin search: first valid index at or after rr_q.
    logic [IDX_W-1:0] grant_c;
    logic [N_REQ-1:0] grant_oh;
    logic [IDX_W:0]   sum, grant_inc;
    logic             found;
    always_comb begin
        grant_c  = '0;
        grant_oh = '0;
        sum      = '0;
        found    = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
            if (!found && req_valid[sum[IDX_W-1:0]]) begin
                found   = 1'b1;
                grant_c = sum[IDX_W-1:0];
            end
        end
        grant_oh[grant_c] = 1'b1;
        grant_inc = {1'b0, grant_q} + (IDX_W+1)'(1);
        if (grant_inc == (IDX_W+1)'(N_REQ)) grant_inc = '0;
    end

    // Digit generation step. Decimal runs one restoring-division bit per cycle:
    // after DATA_W cycles val holds the quotient and rem the digit.
    logic [4:0]        rem_sh;
    logic              ge;
    logic [3:0]        rem_new, dig;
    logic [DATA_W-1:0] val_nx;
    logic              push, gen_done;
    logic [PW-1:0]     nd_nat;
    always_comb begin
        rem_sh  = {rem_q, val_q[DATA_W-1]};
        ge      = (rem_sh >= 5'd10);
        rem_new = ge ? 4'(rem_sh - 5'd10) : rem_sh[3:0];
        unique case (conv_q)
            2'b00: begin
                dig = {3'b000, val_q[0]}; val_nx = val_q >> 1; push = 1'b1; nd_nat = PW'(DATA_W);
            end
            2'b01: begin
                dig = {1'b0, val_q[2:0]}; val_nx = val_q >> 3; push = 1'b1; nd_nat = PW'(ND_O);
            end
            2'b11: begin
                dig = val_q[3:0]; val_nx = val_q >> 4; push = 1'b1; nd_nat = PW'(ND_H);
            end
            default: begin
                dig    = rem_new;
                val_nx = {val_q[DATA_W-2:0], ge};
                push   = (bitcnt_q == SW'(DATA_W - 1));
                nd_nat = PW'(ND_D);
            end
        endcase
        gen_done = push && ((ndig_q + PW'(1) == nd_nat) || (min_q && val_nx == '0));
    end

    // Next character to present. On the GEN exit cycle the MSD is still being pushed,
    // so it is bypassed from the generator instead of read from the stack.
    logic          e_first, is_pad, blank, e_seen, e_seen_nx, e_last;
    logic [PW-1:0] e_pos, e_n, e_len, e_pad, e_j, width_ext;
    logic [3:0]    e_dig;
    logic [7:0]    e_char;
    state_e        e_state;
    always_comb begin
        e_first   = (state_q == StGen);
        e_pos     = e_first ? '0 : pos_q + PW'(1);
        e_n       = e_first ? ndig_q + PW'(1) : ndig_q;
        e_seen    = e_first ? 1'b0 : seen_q;
        width_ext = PW'(width_q);
        e_len     = (e_n > width_ext) ? e_n : width_ext;
        e_pad     = e_len - e_n;
        is_pad    = left_q ? (e_pos >= e_n) : (e_pos < e_pad);
        e_j       = left_q ? (e_n - PW'(1) - e_pos) : (e_len - PW'(1) - e_pos);
        e_dig     = (e_first && e_j == ndig_q) ? dig : stack_q[e_j[SW-1:0]];
        // Decimal leading zeros print as spaces; the LSD always prints.
        blank     = (conv_q == 2'b10) && !e_seen && (e_dig == 4'd0) && (e_j != '0);
        if (is_pad || blank) e_char = 8'h20;
        else if (e_dig < 4'd10) e_char = 8'h30 + {4'h0, e_dig};
        else e_char = 8'h57 + {4'h0, e_dig};
        e_seen_nx = e_seen | (!is_pad && e_dig != 4'd0);
        e_state   = is_pad ? (left_q ? StRpad : StLpad) : StDig;
        e_last    = (e_pos == e_len - PW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            grant_q   <= '0;
            conv_q    <= '0;
            val_q     <= '0;
            width_q   <= '0;
            left_q    <= 1'b0;
            min_q     <= 1'b0;
            rem_q     <= '0;
            bitcnt_q  <= '0;
            ndig_q    <= '0;
            pos_q     <= '0;
            seen_q    <= 1'b0;
            req_ready <= '0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
            out_src   <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid) begin
                        grant_q   <= grant_c;
                        req_ready <= grant_oh;
                        busy      <= 1'b1;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    req_ready <= '0;
                    conv_q    <= conv_arr[grant_q];
                    val_q     <= value_arr[grant_q];
                    width_q   <= width_arr[grant_q];
                    left_q    <= req_left[grant_q];
                    min_q     <= req_min[grant_q];
                    rr_q      <= grant_inc[IDX_W-1:0];
                    out_src   <= grant_q;
                    ndig_q    <= '0;
                    rem_q     <= '0;
                    bitcnt_q  <= '0;
                    state_q   <= StGen;
                end
                StGen: begin
                    val_q    <= val_nx;
                    rem_q    <= push ? 4'd0 : rem_new;
                    bitcnt_q <= push ? '0 : bitcnt_q + SW'(1);
                    if (push) begin
                        stack_q[ndig_q[SW-1:0]] <= dig;
                        ndig_q                  <= ndig_q + PW'(1);
                    end
                    if (gen_done) begin
                        out_valid <= 1'b1;
                        out_char  <= e_char;
                        out_last  <= e_last;
                        pos_q     <= '0;
                        seen_q    <= e_seen_nx;
                        state_q   <= e_state;
                    end
                end
                default: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            pos_q    <= e_pos;
                            out_char <= e_char;
                            out_last <= e_last;
                            seen_q   <= e_seen_nx;
                            state_q  <= e_state;
                        end
                    end
                end
            endcase
        end
    end
endmodule
